p2_grms_qsys_edge_pio_in: RTL and testbench



---
 rtl/p2_grms_qsys_edge_pio_in.sv | 108 ++++++++++
 tb/tb_p2_grms_qsys_edge_pio_in.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/p2_grms_qsys_edge_pio_in.sv
// rtl/p2_grms_qsys_edge_pio_in.sv - Avalon-MM input PIO with sticky edge capture and maskable level irq
// Optional INPUT_SYNC_EN: two-flop synchronizer on in_port (default: single sampling register).
module p2_grms_qsys_edge_pio_in #(
  parameter int WIDTH     = 4,
  parameter int EDGE_TYPE = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] d_sync;
  logic [WIDTH-1:0] d_prev;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] edge_detect;
  logic [WIDTH-1:0] clear_bits;
  logic [31:0]      rd_mux;
  logic             bus_write;
  logic             unused_wdata;

`ifdef INPUT_SYNC_EN
  logic [WIDTH-1:0] s1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1     <= '0;
      d_sync <= '0;
    end else begin
      s1     <= in_port;
      d_sync <= s1;
    end
  end
`else
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d_sync <= '0;
    end else begin
      d_sync <= in_port;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d_prev <= '0;
    end else begin
      d_prev <= d_sync;
    end
  end

  always_comb begin
    edge_detect = d_sync & ~d_prev;
    if (EDGE_TYPE == 1) begin
      edge_detect = ~d_sync & d_prev;
    end else if (EDGE_TYPE == 2) begin
      edge_detect = d_sync ^ d_prev;
    end
  end

  assign bus_write    = chipselect & ~write_n;
  assign clear_bits   = (bus_write && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
  assign unused_wdata = ^writedata;

  // New edges are OR-ed in after the clear so a same-cycle clear never drops one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_capture <= '0;
    end else begin
      edge_capture <= edge_detect | (edge_capture & ~clear_bits);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask <= '0;
    end else if (bus_write && address == 2'd2) begin
      irq_mask <= writedata[WIDTH-1:0];
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux[WIDTH-1:0] = d_sync;
      2'd2:    rd_mux[WIDTH-1:0] = irq_mask;
      2'd3:    rd_mux[WIDTH-1:0] = edge_capture;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_mux;
    end
  end

  assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_p2_grms_qsys_edge_pio_in.sv
// tb/tb_p2_grms_qsys_edge_pio_in.sv - table-driven bench for the edge-capture input PIO
// Three instances share stimulus: rising (u0), falling (u1), any-edge (u2).
module tb_p2_grms_qsys_edge_pio_in;

`ifdef INPUT_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] rd0, rd1, rd2;
  logic        irq0, irq1, irq2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  p2_grms_qsys_edge_pio_in #(.WIDTH(4), .EDGE_TYPE(0)) u0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd0), .irq(irq0));
  p2_grms_qsys_edge_pio_in #(.WIDTH(4), .EDGE_TYPE(1)) u1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd1), .irq(irq1));
  p2_grms_qsys_edge_pio_in #(.WIDTH(4), .EDGE_TYPE(2)) u2 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd2), .irq(irq2));

  typedef struct {
    logic [3:0]  pin;
    logic        wr;
    logic        rd;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        chk_irq;
    logic        exp_irq;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [3:0] pin, logic wr, logic rd, logic [1:0] addr,
                              logic [31:0] wdata, logic [31:0] exp_rd,
                              logic chk_irq, logic exp_irq);
    vec_t v;
    v.pin = pin; v.wr = wr; v.rd = rd; v.addr = addr; v.wdata = wdata;
    v.exp_rd = exp_rd; v.chk_irq = chk_irq; v.exp_irq = exp_irq;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    tick();
    chipselect = 1'b0;
  endtask

  task automatic settle();
    repeat (LAT + 2) tick();
  endtask

  initial begin
    reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_port = 4'b0000;
    #1;
    check("reset_irq_u0", {31'd0, irq0}, 32'd0);
    check("reset_irq_u1", {31'd0, irq1}, 32'd0);
    check("reset_irq_u2", {31'd0, irq2}, 32'd0);
    check("reset_readdata", rd0, 32'd0);
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    for (int a = 0; a < 4; a++) begin
      bus_read(2'(a));
      check($sformatf("reset_read_addr%0d", a), rd0, 32'd0);
      check($sformatf("reset_irq_addr%0d", a), {31'd0, irq0}, 32'd0);
    end

    // pin, wr, rd, addr, wdata, exp_rd, chk_irq, exp_irq
    tbl.push_back(mk(4'b0000, 1, 0, 2'd2, 32'h2,        32'h0, 1, 0));
    tbl.push_back(mk(4'b0000, 0, 1, 2'd2, 32'h0,        32'h2, 1, 0));
    tbl.push_back(mk(4'b0010, 0, 0, 2'd0, 32'h0,        32'h0, 1, 0));
    tbl.push_back(mk(4'b0010, 0, 0, 2'd0, 32'h0,        32'h0, 0, 0));
    tbl.push_back(mk(4'b0010, 0, 0, 2'd0, 32'h0,        32'h0, 1, 1));
    tbl.push_back(mk(4'b0010, 0, 1, 2'd3, 32'h0,        32'h2, 1, 1));
    tbl.push_back(mk(4'b0010, 0, 1, 2'd0, 32'h0,        32'h2, 1, 1));
    tbl.push_back(mk(4'b0110, 0, 0, 2'd0, 32'h0,        32'h0, 1, 1));
    tbl.push_back(mk(4'b0110, 0, 0, 2'd0, 32'h0,        32'h0, 1, 1));
    tbl.push_back(mk(4'b0110, 0, 0, 2'd0, 32'h0,        32'h0, 1, 1));
    tbl.push_back(mk(4'b0110, 0, 1, 2'd3, 32'h0,        32'h6, 1, 1));
    tbl.push_back(mk(4'b0110, 1, 0, 2'd3, 32'h4,        32'h0, 1, 1));
    tbl.push_back(mk(4'b0110, 0, 1, 2'd3, 32'h0,        32'h2, 1, 1));
    tbl.push_back(mk(4'b0110, 1, 0, 2'd3, 32'h2,        32'h0, 1, 0));
    tbl.push_back(mk(4'b0110, 0, 1, 2'd3, 32'h0,        32'h0, 1, 0));
    tbl.push_back(mk(4'b0110, 0, 1, 2'd1, 32'h0,        32'h0, 1, 0));
    tbl.push_back(mk(4'b0110, 1, 0, 2'd0, 32'hFFFFFFFF, 32'h0, 1, 0));
    tbl.push_back(mk(4'b0110, 1, 0, 2'd1, 32'h0000000F, 32'h0, 1, 0));
    tbl.push_back(mk(4'b0110, 0, 1, 2'd0, 32'h0,        32'h6, 1, 0));
    tbl.push_back(mk(4'b0110, 0, 1, 2'd1, 32'h0,        32'h0, 1, 0));
    tbl.push_back(mk(4'b0110, 0, 1, 2'd2, 32'h0,        32'h2, 1, 0));
    tbl.push_back(mk(4'b0110, 1, 0, 2'd2, 32'hFFFFFFF2, 32'h0, 1, 0));
    tbl.push_back(mk(4'b0110, 0, 1, 2'd2, 32'h0,        32'h2, 1, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      in_port    = tbl[i].pin;
      address    = tbl[i].addr;
      writedata  = tbl[i].wdata;
      chipselect = tbl[i].wr | tbl[i].rd;
      write_n    = ~tbl[i].wr;
      tick();
      chipselect = 1'b0; write_n = 1'b1;
      if (tbl[i].rd) check($sformatf("vec%0d_readdata", i), rd0, tbl[i].exp_rd);
      if (tbl[i].chk_irq) check($sformatf("vec%0d_irq", i), {31'd0, irq0}, {31'd0, tbl[i].exp_irq});
    end

    // Exact capture latency on bit 3 via irq.
    bus_write(2'd3, 32'hF);
    bus_write(2'd2, 32'h8);
    in_port = 4'b1110;
    for (int i = 0; i < LAT; i++) begin
      tick();
      check($sformatf("latency_irq_low_%0d", i), {31'd0, irq0}, 32'd0);
    end
    tick();
    check("latency_irq_high", {31'd0, irq0}, 32'd1);

    // Set-wins: clear write lands on the same edge that captures bit 0.
    bus_write(2'd2, 32'h2);
    bus_write(2'd3, 32'hF);
    in_port = 4'b1111;
    tick();
    in_port = 4'b1110;
    repeat (LAT - 1) tick();
    bus_write(2'd3, 32'h1);
    check("setwins_irq", {31'd0, irq0}, 32'd0);
    bus_read(2'd3);
    check("setwins_capture", rd0, 32'h1);

    // Falling / any-edge on bit 3.
    in_port = 4'b0110;
    settle();
    bus_write(2'd3, 32'hF);
    in_port = 4'b1110;
    settle();
    bus_read(2'd3);
    check("rise_u0", rd0, 32'h8);
    check("rise_u1_falling", rd1, 32'h0);
    check("rise_u2_any", rd2, 32'h8);
    bus_write(2'd3, 32'hF);
    in_port = 4'b0110;
    settle();
    bus_read(2'd3);
    check("fall_u0", rd0, 32'h0);
    check("fall_u1_falling", rd1, 32'h8);
    check("fall_u2_any", rd2, 32'h8);

    // Masked capture, late unmask, then reset mid-cycle.
    bus_write(2'd2, 32'h0);
    in_port = 4'b0010;
    settle();
    bus_write(2'd3, 32'hF);
    in_port = 4'b0110;
    settle();
    check("masked_irq", {31'd0, irq0}, 32'd0);
    bus_write(2'd2, 32'h4);
    check("unmask_irq", {31'd0, irq0}, 32'd1);
    bus_read(2'd3);
    check("unmask_capture", rd0, 32'h4);
    #2;
    reset_n = 1'b0;
    #1;
    check("midreset_irq", {31'd0, irq0}, 32'd0);
    check("midreset_readdata", rd0, 32'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    settle();
    bus_read(2'd2);
    check("postreset_mask", rd0, 32'h0);
    bus_read(2'd3);
    check("release_rise_u0", rd0, 32'h6);
    check("release_rise_u1", rd1, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
